// File: rtl/prime_sieve_sequencer_if.sv
// Bus between prime_sieve_sequencer (master) and prime_number_core (slave):
// launch strobe/write, limit and read address out; is-prime bit, ack and stall back.
interface prime_sieve_sequencer_if #(
  parameter int PRIME_BITS = 20
);
  logic                  core_stb_o;
  logic                  core_we_o;
  logic [PRIME_BITS-1:0] core_dat_o;
  logic [PRIME_BITS-1:0] core_address_o;
  logic                  core_dat_i;
  logic                  core_ack_i;
  logic                  core_stall_i;

  modport master (
    output core_stb_o,
    output core_we_o,
    output core_dat_o,
    output core_address_o,
    input  core_dat_i,
    input  core_ack_i,
    input  core_stall_i
  );

  modport slave (
    input  core_stb_o,
    input  core_we_o,
    input  core_dat_o,
    input  core_address_o,
    output core_dat_i,
    output core_ack_i,
    output core_stall_i
  );
endinterface

// File: rtl/prime_sieve_sequencer.sv
// Benchmark sequencer: repeats prime_number_core sieve runs until a cycle budget is spent.
// Define PRIME_SIEVE_SEQUENCER_VERIFY_EN to add the read-back scan that counts primes <= limit.
module prime_sieve_sequencer #(
  parameter int PRIME_BITS = 20,
  parameter int CYCLE_BITS = 32,
  parameter int PASS_BITS  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [PRIME_BITS-1:0]   limit_i,
  input  logic [CYCLE_BITS-1:0]   duration_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [PASS_BITS-1:0]    passes_o,
  output logic [CYCLE_BITS-1:0]   cycles_o,
  output logic [PRIME_BITS-1:0]   count_o,
  prime_sieve_sequencer_if.master core
);

`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_ACK, WAIT_RUN, SCAN_ADDR, SCAN_SAMPLE, FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_ACK, WAIT_RUN, FINISH
  } state_t;
`endif

  state_t                state_q;
  logic [CYCLE_BITS-1:0] duration_q;
  logic [CYCLE_BITS-1:0] elapsed_q;
  logic [CYCLE_BITS-1:0] elapsed_nx;

  function automatic logic [CYCLE_BITS-1:0] sat_inc_cycles(input logic [CYCLE_BITS-1:0] v);
    return (&v) ? v : v + CYCLE_BITS'(1);
  endfunction

  function automatic logic [PASS_BITS-1:0] sat_inc_passes(input logic [PASS_BITS-1:0] v);
    return (&v) ? v : v + PASS_BITS'(1);
  endfunction

  // Includes the current cycle, so a completion cycle is counted in cycles_o.
  assign elapsed_nx = sat_inc_cycles(elapsed_q);

`ifndef PRIME_SIEVE_SEQUENCER_VERIFY_EN
  logic unused_dat;
  assign unused_dat          = core.core_dat_i;
  assign count_o             = '0;
  assign core.core_address_o = '0;
`endif

  // core_dat_o doubles as the captured limit; it only changes on an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      duration_q      <= '0;
      elapsed_q       <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      passes_o        <= '0;
      cycles_o        <= '0;
      core.core_stb_o <= 1'b0;
      core.core_we_o  <= 1'b0;
      core.core_dat_o <= '0;
`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
      count_o             <= '0;
      core.core_address_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            duration_q      <= duration_i;
            elapsed_q       <= '0;
            passes_o        <= '0;
            cycles_o        <= '0;
            busy_o          <= 1'b1;
            core.core_stb_o <= 1'b1;
            core.core_we_o  <= 1'b1;
            core.core_dat_o <= limit_i;
`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
            count_o             <= '0;
            core.core_address_o <= '0;
`endif
            state_q <= LAUNCH;
          end
        end

        LAUNCH: begin
          elapsed_q <= elapsed_nx;
          // A core still busy from before our reset simply delays acceptance.
          if (!core.core_stall_i) begin
            core.core_stb_o <= 1'b0;
            core.core_we_o  <= 1'b0;
            state_q         <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          elapsed_q <= elapsed_nx;
          if (core.core_ack_i && core.core_stall_i) begin
            state_q <= WAIT_RUN;
          end
        end

        WAIT_RUN: begin
          elapsed_q <= elapsed_nx;
          if (!core.core_stall_i) begin
            passes_o <= sat_inc_passes(passes_o);
            cycles_o <= elapsed_nx;
            if (elapsed_nx >= duration_q) begin
`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
              core.core_address_o <= '0;
              core.core_stb_o     <= 1'b1;
              core.core_we_o      <= 1'b0;
              state_q             <= SCAN_ADDR;
`else
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state_q <= FINISH;
`endif
            end else begin
              core.core_stb_o <= 1'b1;
              core.core_we_o  <= 1'b1;
              state_q         <= LAUNCH;
            end
          end
        end

`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
        SCAN_ADDR: begin
          core.core_stb_o <= 1'b0;
          state_q         <= SCAN_SAMPLE;
        end

        // Address stays put here: the core's read data is registered.
        SCAN_SAMPLE: begin
          if (core.core_dat_i) begin
            count_o <= count_o + PRIME_BITS'(1);
          end
          if (core.core_address_o == core.core_dat_o) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= FINISH;
          end else begin
            core.core_address_o <= core.core_address_o + PRIME_BITS'(1);
            core.core_stb_o     <= 1'b1;
            state_q             <= SCAN_ADDR;
          end
        end
`endif

        FINISH: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sieve_sequencer.sv
// Self-checking bench for prime_sieve_sequencer with a behavioural prime_number_core model.
// Expectations adapt to whether PRIME_SIEVE_SEQUENCER_VERIFY_EN is defined.
`timescale 1ns/1ps

`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      failures++; \
      $error("FAIL %s observed=%0d expected=%0d", TAG, OBS, EXP); \
    end \
  end

module tb_prime_sieve_sequencer;
  localparam int PB = 20;
  localparam int CB = 32;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_ni;

  logic          start0, start1;
  logic [PB-1:0] lim0, lim1;
  logic [CB-1:0] dur0, dur1;
  logic          busy0, busy1, done0, done1;
  logic [15:0]   passes0;
  logic [1:0]    passes1;
  logic [CB-1:0] cycles0, cycles1;
  logic [PB-1:0] count0, count1;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int run_fixed = -1;
  int exp_lim0  = 0;
  int exp_lim1  = 0;

  prime_sieve_sequencer_if #(.PRIME_BITS(PB)) cif [2] ();

  prime_sieve_sequencer #(.PRIME_BITS(PB), .CYCLE_BITS(CB), .PASS_BITS(16)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start0), .limit_i(lim0), .duration_i(dur0),
    .busy_o(busy0), .done_o(done0), .passes_o(passes0), .cycles_o(cycles0),
    .count_o(count0), .core(cif[0])
  );

  prime_sieve_sequencer #(.PRIME_BITS(PB), .CYCLE_BITS(CB), .PASS_BITS(2)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start1), .limit_i(lim1), .duration_i(dur1),
    .busy_o(busy1), .done_o(done1), .passes_o(passes1), .cycles_o(cycles1),
    .count_o(count1), .core(cif[1])
  );

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_count(input int lim);
    int c;
    c = 0;
`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
    for (int k = 0; k <= lim; k++) if (is_prime(k)) c++;
`endif
    return c;
  endfunction

  // Core model: accepts a launch when strobed while not stalled, acks one edge later,
  // stays busy for a random (or fixed) time; reads are registered by one cycle.
  for (genvar g = 0; g < 2; g++) begin : g_core
    int running = 0, acc_pend = 0, rd_pend = 0, owned = 0, run_left = 0;
    int comp_cnt = 0, last_comp = 0, prev_comp = 0, first_launch = 0;
    int launch_err = 0, addr_err = 0, done_cnt = 0, done_at = 0;
    bit busy_prev = 1'b0, stb_at_rise = 1'b0;
    logic [PB-1:0] rd_addr = '0;
    wire busy_w = (g == 0) ? busy0 : busy1;
    wire done_w = (g == 0) ? done0 : done1;

    always begin
      @(negedge clk_i);
      if (busy_w === 1'b1 && !busy_prev) begin
        first_launch = cyc;
        stb_at_rise  = cif[g].core_stb_o;
        comp_cnt = 0; owned = 0; done_cnt = 0; launch_err = 0; addr_err = 0;
        last_comp = 0; prev_comp = 0;
      end
      if (acc_pend != 0) begin
        acc_pend = 0;
        running  = 1;
        run_left = (run_fixed >= 0) ? run_fixed : int'($urandom_range(0, 40));
        cif[g].core_ack_i   = 1'b1;
        cif[g].core_stall_i = 1'b1;
      end else begin
        cif[g].core_ack_i = 1'b0;
        if (running != 0) begin
          if (run_left == 0) begin
            running = 0;
            cif[g].core_stall_i = 1'b0;
            if (owned != 0) begin
              comp_cnt++;
              prev_comp = last_comp;
              last_comp = cyc;
            end
          end else begin
            run_left--;
          end
        end else begin
          cif[g].core_stall_i = 1'b0;
        end
      end
      if (rd_pend != 0) begin
        cif[g].core_dat_i = is_prime(int'(rd_addr));
        if (cif[g].core_address_o !== rd_addr) addr_err++;
        rd_pend = 0;
      end else begin
        cif[g].core_dat_i = 1'($urandom);
      end
      if (cif[g].core_stb_o === 1'b1 && cif[g].core_we_o === 1'b0) begin
        rd_pend = 1;
        rd_addr = cif[g].core_address_o;
      end
      if (cif[g].core_stb_o === 1'b1 && cif[g].core_we_o === 1'b1 && cif[g].core_stall_i === 1'b0) begin
        acc_pend = 1;
        owned    = (busy_w === 1'b1) ? 1 : 0;
        if (cif[g].core_dat_o !== PB'((g == 0) ? exp_lim0 : exp_lim1)) launch_err++;
      end
      if (done_w === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      busy_prev = (busy_w === 1'b1);
    end
  end

  task automatic kick0(input int lim, input int dur, output int s);
    exp_lim0 = lim;
    lim0     = PB'(lim);
    dur0     = CB'(dur);
    start0   = 1'b1;
    s        = cyc;
    @(negedge clk_i);
    start0 = 1'b0;
  endtask

  task automatic finish0(input int lim, input int dur, input bit chatter, input int s, input string tag);
    int n, budget, comp, first, last, exp_done;
    budget = dur + 2 * lim + 800;
    n = 0;
    while (done0 !== 1'b1 && n < budget) begin
      if (chatter) begin
        start0 = 1'($urandom_range(0, 1));
        lim0   = PB'($urandom);
      end
      @(negedge clk_i);
      n++;
    end
    start0 = 1'b0;
    `CHK({tag, "/timeout"}, (n < budget), 1'b1)
    if (n >= budget) begin
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
    end
    repeat (3) @(negedge clk_i);
    comp  = g_core[0].comp_cnt;
    first = g_core[0].first_launch;
    last  = g_core[0].last_comp;
`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
    exp_done = last + 2 * (lim + 1) + 1;
`else
    exp_done = last + 1;
`endif
    `CHK({tag, "/first_launch"}, first, s + 1)
    `CHK({tag, "/stb_at_busy"}, g_core[0].stb_at_rise, 1'b1)
    `CHK({tag, "/passes"}, int'(passes0), (comp > 65535) ? 65535 : comp)
    `CHK({tag, "/cycles"}, int'(cycles0), last - first + 1)
    `CHK({tag, "/budget_met"}, (cycles0 >= CB'(dur)), 1'b1)
    if (comp > 1) `CHK({tag, "/no_extra_pass"}, (g_core[0].prev_comp - first + 1 < dur), 1'b1)
    if (dur == 0) `CHK({tag, "/one_pass"}, comp, 1)
    `CHK({tag, "/count"}, int'(count0), exp_count(lim))
    `CHK({tag, "/done_pulses"}, g_core[0].done_cnt, 1)
    `CHK({tag, "/done_at"}, g_core[0].done_at, exp_done)
    `CHK({tag, "/busy_after"}, busy0, 1'b0)
    `CHK({tag, "/launch_limit"}, g_core[0].launch_err, 0)
`ifdef PRIME_SIEVE_SEQUENCER_VERIFY_EN
    `CHK({tag, "/addr_stable"}, g_core[0].addr_err, 0)
`else
    `CHK({tag, "/addr_tied"}, cif[0].core_address_o, PB'(0))
`endif
  endtask

  task automatic run0(input int lim, input int dur, input bit chatter, input string tag);
    int s;
    kick0(lim, dur, s);
    finish0(lim, dur, chatter, s, tag);
  endtask

  initial begin
    int s, n, lim, dur;
    rst_ni = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    lim0 = '0; lim1 = '0; dur0 = '0; dur1 = '0;
    repeat (4) @(negedge clk_i);
    `CHK("reset/busy", busy0, 1'b0)
    `CHK("reset/done", done0, 1'b0)
    `CHK("reset/passes", passes0, 16'd0)
    `CHK("reset/cycles", cycles0, 32'd0)
    `CHK("reset/count", count0, 20'd0)
    `CHK("reset/stb", cif[0].core_stb_o, 1'b0)
    `CHK("reset/we", cif[0].core_we_o, 1'b0)
    `CHK("reset/dat", cif[0].core_dat_o, 20'd0)
    `CHK("reset/addr", cif[0].core_address_o, 20'd0)
    rst_ni = 1'b1;
    @(negedge clk_i);

    run0(100, 0, 1'b0, "lim100");
    run0(2, 0, 1'b0, "lim2");
    run0(0, 0, 1'b0, "lim0");
    run0(100, 300, 1'b1, "chatter");
    for (int i = 0; i < 4; i++) begin
      lim = int'($urandom_range(0, 150));
      dur = int'($urandom_range(0, 800));
      run0(lim, dur, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // Reset while the core is mid-run; the core keeps stalling afterwards.
    run_fixed = 80;
    kick0(100, 0, s);
    n = 0;
    while (cif[0].core_ack_i !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    `CHK("midrst/ack_seen", (n < 20), 1'b1)
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    `CHK("midrst/busy", busy0, 1'b0)
    `CHK("midrst/stb", cif[0].core_stb_o, 1'b0)
    `CHK("midrst/passes", passes0, 16'd0)
    rst_ni = 1'b1;
    @(negedge clk_i);
    kick0(100, 0, s);
    repeat (5) @(negedge clk_i);
    `CHK("midrst/stb_held", cif[0].core_stb_o, 1'b1)
    `CHK("midrst/we_held", cif[0].core_we_o, 1'b1)
    run_fixed = -1;
    finish0(100, 0, 1'b0, s, "post_reset");

    run0(1000, 50000, 1'b1, "lim1000");

    // Two-bit pass counter must stick at 3.
    exp_lim1 = 10;
    lim1 = PB'(10);
    dur1 = CB'(2000);
    start1 = 1'b1;
    @(negedge clk_i);
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    `CHK("sat/timeout", (n < 4000), 1'b1)
    repeat (3) @(negedge clk_i);
    `CHK("sat/passes", passes1, 2'd3)
    `CHK("sat/count", int'(count1), exp_count(10))
    `CHK("sat/cycles", int'(cycles1), g_core[1].last_comp - g_core[1].first_launch + 1)
    `CHK("sat/launch_limit", g_core[1].launch_err, 0)
    `CHK("sat/done_pulses", g_core[1].done_cnt, 1)

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
